emg_scan_sequencer: RTL and testbench

EMG_SCAN_SEQUENCER -- requirements
Module: emg_scan_sequencer

---
 rtl/emg_pkg.sv | 7 +
 rtl/emg_ch_counter.sv | 19 +
 rtl/emg_scan_sequencer.sv | 141 ++++++++++++++
 tb/tb_emg_scan_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/emg_pkg.sv
// emg_pkg: shared FSM state encoding and default sizing for the EMG scan sequencer.
package emg_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, HOLD, CONVERT, EMIT} state_t;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int DATA_W_DEF = 12;
  localparam int SET_W = 8;
endpackage

// File: rtl/emg_ch_counter.sv
// emg_ch_counter: wrapping channel index with increment, direct load and terminal count.
module emg_ch_counter #(
  parameter int MAX = 7,
  parameter int W = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == W'(MAX);
  assign cnt = cnt_q;
  always_comb cnt_d = load ? load_val : inc ? (tc ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge Clk) cnt_q <= Reset ? '0 : cnt_d;
endmodule

// File: rtl/emg_scan_sequencer.sv
// emg_scan_sequencer: multiplexed EMG channel scanner driving mux, sample-and-hold and ADC.
// Define EMG_SCAN_CH_MASK_EN to add the Ch_mask input that skips unselected channels.
module emg_scan_sequencer import emg_pkg::*; #(
  parameter int NUM_CH = 8,
  parameter int CH_BITS = 3,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               Adc_done,
  input  logic [DATA_W-1:0]  Adc_data,
`ifdef EMG_SCAN_CH_MASK_EN
  input  logic [NUM_CH-1:0]  Ch_mask,
`endif
  output logic [CH_BITS-1:0] Mux_sel,
  output logic               Sh_hold,
  output logic               Adc_start,
  output logic               Sample_valid,
  output logic [DATA_W-1:0]  Sample_data,
  output logic [CH_BITS-1:0] Sample_ch,
  output logic               Frame_done,
  output logic               Busy
);
  state_t state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic hold_q, hold_d, start_q, start_d, valid_q, valid_d, fd_q, fd_d, busy_q, busy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_BITS-1:0] sch_q, sch_d;
  logic [CH_BITS-1:0] ch, first_ch, adv_ch, load_val;
  logic tc, inc, load, go, last;
`ifdef EMG_SCAN_CH_MASK_EN
  localparam bit USE_MASK = 1'b1;
  logic [CH_BITS-1:0] hi_ch;
  // Nearest enabled channel at or after (incl) / strictly after cur, wrapping.
  function automatic logic [CH_BITS-1:0] next_ch(input logic [NUM_CH-1:0] m,
                                                 input logic [CH_BITS-1:0] cur, input logic incl);
    int best;
    next_ch = cur;
    best = NUM_CH + 1;
    for (int i = 0; i < NUM_CH; i++) begin
      int dist;
      dist = i - int'(cur);
      if (dist < 0 || (dist == 0 && !incl)) dist += NUM_CH;
      if (m[i] && dist < best) begin
        best = dist;
        next_ch = CH_BITS'(i);
      end
    end
  endfunction
  always_comb begin
    hi_ch = '0;
    for (int i = 0; i < NUM_CH; i++) if (Ch_mask[i]) hi_ch = CH_BITS'(i);
  end
  assign go = |Ch_mask;
  assign last = ch == hi_ch;
  assign first_ch = next_ch(Ch_mask, ch, 1'b1);
  assign adv_ch = next_ch(Ch_mask, ch, 1'b0);
`else
  localparam bit USE_MASK = 1'b0;
  assign go = 1'b1;
  assign last = tc;
  assign first_ch = ch;
  assign adv_ch = ch;
`endif
  emg_ch_counter #(.MAX(NUM_CH - 1), .W(CH_BITS)) u_ch (
    .Clk(Clk), .Reset(Reset), .inc(inc), .load(load), .load_val(load_val), .cnt(ch), .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    set_d = set_q;
    data_d = data_q;
    sch_d = sch_q;
    fd_d = 1'b0;
    inc = 1'b0;
    load = 1'b0;
    load_val = state_q == IDLE ? first_ch : adv_ch;
    case (state_q)
      IDLE: if (Enable && go) begin
        state_d = SETTLE;
        load = USE_MASK;
      end
      SETTLE: begin
        set_d = set_q + 1'b1;
        if (set_q == SET_W'(SETTLE_CYC - 1)) begin
          state_d = HOLD;
          set_d = '0;
        end
      end
      HOLD: state_d = CONVERT;
      CONVERT: if (Adc_done) begin
        state_d = EMIT;
        data_d = Adc_data;
        sch_d = ch;
        fd_d = last;
      end
      EMIT: begin
        state_d = Enable && go ? SETTLE : IDLE;
        inc = !USE_MASK;
        load = USE_MASK;
      end
      default: state_d = IDLE;
    endcase
    hold_d = state_d == HOLD || state_d == CONVERT;
    start_d = state_d == HOLD;
    valid_d = state_d == EMIT;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      set_q <= '0;
      hold_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      fd_q <= 1'b0;
      busy_q <= 1'b0;
      data_q <= '0;
      sch_q <= '0;
    end else begin
      state_q <= state_d;
      set_q <= set_d;
      hold_q <= hold_d;
      start_q <= start_d;
      valid_q <= valid_d;
      fd_q <= fd_d;
      busy_q <= busy_d;
      data_q <= data_d;
      sch_q <= sch_d;
    end
  end
  assign Mux_sel = ch;
  assign Sh_hold = hold_q;
  assign Adc_start = start_q;
  assign Sample_valid = valid_q;
  assign Sample_data = data_q;
  assign Sample_ch = sch_q;
  assign Frame_done = fd_q;
  assign Busy = busy_q;
endmodule

// File: tb/tb_emg_scan_sequencer.sv
// tb_emg_scan_sequencer: vector table, randomized transaction model and corner sequences.
module tb_emg_scan_sequencer;
  localparam int NUM_CH = 8;
  localparam int CH_BITS = 3;
  localparam int S = 4;
  localparam int DW = 12;
  logic Clk = 1'b0;
  logic Reset, Enable, Adc_done;
  logic [DW-1:0] Adc_data, Sample_data;
  logic [CH_BITS-1:0] Mux_sel, Sample_ch;
  logic Sh_hold, Adc_start, Sample_valid, Frame_done, Busy;
  int checks = 0;
  int passed = 0;
  typedef struct {
    logic en;
    logic done;
    logic [4:0] o;
    logic [CH_BITS-1:0] ch;
    logic [DW-1:0] data;
  } vec_t;
  vec_t tv[9];
  always #5 Clk = ~Clk;
  emg_scan_sequencer #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .SETTLE_CYC(S), .DATA_W(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Adc_done(Adc_done), .Adc_data(Adc_data),
    .Mux_sel(Mux_sel), .Sh_hold(Sh_hold), .Adc_start(Adc_start), .Sample_valid(Sample_valid),
    .Sample_data(Sample_data), .Sample_ch(Sample_ch), .Frame_done(Frame_done), .Busy(Busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic do_reset;
    Reset = 1'b1;
    Enable = 1'b0;
    Adc_done = 1'b0;
    Adc_data = '0;
    tick;
    tick;
    Reset = 1'b0;
  endtask
  task automatic wait_start;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (Adc_start) ok = 1'b1;
      else tick;
    end
    if (!ok) chk("start_timeout", 32'(Adc_start), 32'd1);
  endtask
  task automatic service(input int d, output logic [CH_BITS-1:0] ch, output logic fd);
    logic [DW-1:0] v;
    wait_start;
    repeat (d) tick;
    v = DW'($urandom);
    Adc_done = 1'b1;
    Adc_data = v;
    tick;
    Adc_done = 1'b0;
    chk("svc_valid", 32'(Sample_valid), 32'd1);
    chk("svc_data", 32'(Sample_data), 32'(v));
    ch = Sample_ch;
    fd = Frame_done;
  endtask
  initial begin
    logic [CH_BITS-1:0] ch;
    logic fd;
    int start_at, done_at, valid_at, exp_ch, last_ch;
    bit inflight, holding, en_r, s_now, v_now;
    logic [DW-1:0] exp_data, last_data;
    tv[0] = '{1'b0, 1'b1, 5'b00000, 3'd0, 12'h000};
    tv[1] = '{1'b1, 1'b0, 5'b10000, 3'd0, 12'h000};
    tv[2] = '{1'b1, 1'b1, 5'b10000, 3'd0, 12'h000};
    tv[3] = '{1'b1, 1'b0, 5'b10000, 3'd0, 12'h000};
    tv[4] = '{1'b1, 1'b0, 5'b10000, 3'd0, 12'h000};
    tv[5] = '{1'b1, 1'b0, 5'b11100, 3'd0, 12'h000};
    tv[6] = '{1'b1, 1'b0, 5'b10100, 3'd0, 12'h000};
    tv[7] = '{1'b1, 1'b1, 5'b10010, 3'd0, 12'h107};
    tv[8] = '{1'b1, 1'b0, 5'b10000, 3'd0, 12'h107};
    do_reset;
    chk("reset_outs", 32'({Busy, Adc_start, Sh_hold, Sample_valid, Frame_done, Mux_sel, Sample_ch, Sample_data}), 32'd0);
    for (int i = 0; i < 9; i++) begin
      Enable = tv[i].en;
      Adc_done = tv[i].done;
      Adc_data = DW'(12'h100 + i);
      tick;
      chk("tv_ctl", 32'({Busy, Adc_start, Sh_hold, Sample_valid, Frame_done}), 32'(tv[i].o));
      chk("tv_ch", 32'(Sample_ch), 32'(tv[i].ch));
      chk("tv_data", 32'(Sample_data), 32'(tv[i].data));
    end
    do_reset;
    start_at = -1; done_at = -1; valid_at = -1; exp_ch = 0; last_ch = 0;
    inflight = 1'b0; holding = 1'b0; en_r = 1'b0; exp_data = '0; last_data = '0;
    for (int n = 0; n < 3000; n++) begin
      tick;
      s_now = n == start_at;
      v_now = n == valid_at;
      chk("rnd_start", 32'(Adc_start), 32'(s_now));
      chk("rnd_valid", 32'(Sample_valid), 32'(v_now));
      chk("rnd_busy", 32'(Busy), 32'(inflight));
      chk("rnd_hold", 32'(Sh_hold), 32'(s_now || (holding && !v_now)));
      chk("rnd_frame", 32'(Frame_done), 32'(v_now && exp_ch == NUM_CH - 1));
      if (v_now) begin
        last_ch = exp_ch;
        last_data = exp_data;
      end
      chk("rnd_ch", 32'(Sample_ch), 32'(last_ch));
      chk("rnd_data", 32'(Sample_data), 32'(last_data));
      if (s_now) begin
        chk("rnd_mux", 32'(Mux_sel), 32'(exp_ch));
        done_at = n + int'($urandom_range(1, 4));
        holding = 1'b1;
      end
      if (v_now) begin
        inflight = 1'b0;
        holding = 1'b0;
        exp_ch = (exp_ch + 1) % NUM_CH;
      end
      if ($urandom_range(0, en_r ? 59 : 9) == 0) en_r = !en_r;
      Enable = en_r;
      Adc_done = 1'b0;
      if (n == done_at) begin
        exp_data = DW'($urandom);
        Adc_done = 1'b1;
        Adc_data = exp_data;
        valid_at = n + 1;
        done_at = -1;
      end else if (done_at < 0 && $urandom_range(0, 3) == 0) begin
        Adc_done = 1'b1;
        Adc_data = DW'($urandom);
      end
      if (!inflight && en_r) begin
        inflight = 1'b1;
        start_at = n + S + 1;
      end
    end
    do_reset;
    Enable = 1'b1;
    for (int k = 0; k < 11; k++) begin
      service(2, ch, fd);
      chk("frame_ch", 32'(ch), 32'(k % NUM_CH));
      chk("frame_done", 32'(fd), 32'(k % NUM_CH == NUM_CH - 1));
    end
    wait_start;
    tick;
    Enable = 1'b0;
    tick;
    Adc_done = 1'b1;
    Adc_data = 12'h5a5;
    tick;
    Adc_done = 1'b0;
    chk("drop_valid", 32'(Sample_valid), 32'd1);
    chk("drop_ch", 32'(Sample_ch), 32'd3);
    tick;
    chk("drop_idle", 32'({Busy, Sample_valid}), 32'd0);
    repeat (3) tick;
    chk("drop_stay", 32'(Busy), 32'd0);
    chk("drop_hold_ch", 32'(Sample_ch), 32'd3);
    Enable = 1'b1;
    service(1, ch, fd);
    chk("resume_ch", 32'(ch), 32'd4);
    wait_start;
    tick;
    Reset = 1'b1;
    Adc_done = 1'b1;
    tick;
    chk("mid_reset", 32'({Busy, Adc_start, Sh_hold, Sample_valid, Frame_done, Mux_sel, Sample_ch, Sample_data}), 32'd0);
    Reset = 1'b0;
    Adc_done = 1'b0;
    service(1, ch, fd);
    chk("post_reset_ch", 32'(ch), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
